// File: rtl/ola_pkg.sv
// Shared constants, sample type and saturating adder for overlap_add.
// sat_add adds at DATA_W+1 bits, clamps to the signed range, flags overflow.
package ola_pkg;

  localparam int DATA_W  = 32;
  localparam int FRAME_N = 32;
  localparam int HOP     = FRAME_N / 2;
  localparam int IDX_W   = $clog2(FRAME_N);
  localparam int TAIL_W  = $clog2(HOP);

  typedef logic signed [DATA_W-1:0] sample_t;

  typedef struct packed {
    logic    ovf;
    sample_t sum;
  } sat_res_t;

  function automatic sat_res_t sat_add(
    input sample_t a,
    input sample_t b
  );
    logic [DATA_W:0] s;
    sat_res_t        r;
    s     = {a[DATA_W-1], a} + {b[DATA_W-1], b};
    r.ovf = s[DATA_W] ^ s[DATA_W-1];
    if (!r.ovf)
      r.sum = s[DATA_W-1:0];
    else if (s[DATA_W])
      r.sum = {1'b1, {(DATA_W-1){1'b0}}};
    else
      r.sum = {1'b0, {(DATA_W-1){1'b1}}};
    return r;
  endfunction

endpackage

// File: rtl/ola_tail_buf.sv
// Tail storage: HOP x DATA_W register file, one write and one comb read port.
// Ports: clk, reset (sync clear), we/waddr/wdata, raddr/rdata.
module ola_tail_buf
  import ola_pkg::*;
(
  input  logic              clk,
  input  logic              reset,
  input  logic              we,
  input  logic [TAIL_W-1:0] waddr,
  input  logic [DATA_W-1:0] wdata,
  input  logic [TAIL_W-1:0] raddr,
  output logic [DATA_W-1:0] rdata
);

  logic [DATA_W-1:0] mem [HOP];

  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < HOP; i++)
        mem[i] <= '0;
    end else if (we) begin
      mem[waddr] <= wdata;
    end
  end

  assign rdata = mem[raddr];

endmodule

// File: rtl/overlap_add.sv
// 50% overlap-add of 32-point IFFT frames, hop 16, saturated registered out.
// Ports: clk, reset, enable_in, ifft_in_re -> enable_out, ola_out, frame_done, sat_flag.
module overlap_add
  import ola_pkg::*;
#(
  parameter int IN_SHIFT = 0
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              enable_in,
  input  logic [DATA_W-1:0] ifft_in_re,
  output logic              enable_out,
  output logic [DATA_W-1:0] ola_out,
  output logic              frame_done,
  output logic              sat_flag
);

  logic [IDX_W-1:0]  idx;
  logic              add_ph;
  sample_t           x;
  logic [DATA_W-1:0] tail_rd;
  sat_res_t          res;

  // upper half of the frame only refills the tail
  assign add_ph = ~idx[IDX_W-1];
  assign x      = $signed(ifft_in_re) >>> IN_SHIFT;
  assign res    = sat_add(x, sample_t'(tail_rd));

  ola_tail_buf u_tail (
    .clk   (clk),
    .reset (reset),
    .we    (enable_in & ~add_ph),
    .waddr (idx[TAIL_W-1:0]),
    .wdata (x),
    .raddr (idx[TAIL_W-1:0]),
    .rdata (tail_rd)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      idx        <= '0;
      enable_out <= 1'b0;
      ola_out    <= '0;
      frame_done <= 1'b0;
      sat_flag   <= 1'b0;
    end else begin
      enable_out <= enable_in & add_ph;
      frame_done <= enable_in & (&idx);
      if (enable_in)
        idx <= idx + 1'b1;
      if (enable_in && add_ph) begin
        ola_out <= res.sum;
        if (res.ovf)
          sat_flag <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_overlap_add.sv
// Directed + random bench for overlap_add, two instances (IN_SHIFT 0 and 2).
// Expected values come from a history-queue overlap-add model.
module tb_overlap_add;

  logic        clk = 1'b0;
  logic        reset;
  logic        enable_in;
  logic [31:0] ifft_in_re;

  logic        eo0, fd0, sf0;
  logic [31:0] oo0;
  logic        eo2, fd2, sf2;
  logic [31:0] oo2;

  int n_chk   = 0;
  int n_fail  = 0;
  int pulses0 = 0;

  int raw[$];
  bit esat[2];

  always #5 clk = ~clk;

  overlap_add #(.IN_SHIFT(0)) u0 (
    .clk        (clk),
    .reset      (reset),
    .enable_in  (enable_in),
    .ifft_in_re (ifft_in_re),
    .enable_out (eo0),
    .ola_out    (oo0),
    .frame_done (fd0),
    .sat_flag   (sf0)
  );

  overlap_add #(.IN_SHIFT(2)) u2 (
    .clk        (clk),
    .reset      (reset),
    .enable_in  (enable_in),
    .ifft_in_re (ifft_in_re),
    .enable_out (eo2),
    .ola_out    (oo2),
    .frame_done (fd2),
    .sat_flag   (sf2)
  );

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  function automatic longint xs(input int v, input int sh);
    longint t;
    t = v;
    return t >>> sh;
  endfunction

  task automatic do_reset();
    @(negedge clk);
    reset      = 1'b1;
    enable_in  = 1'b1;
    ifft_in_re = $urandom;
    @(posedge clk);
    #1;
    raw.delete();
    esat[0] = 1'b0;
    esat[1] = 1'b0;
    chk("rst_en0", {31'd0, eo0}, 32'd0);
    chk("rst_out0", oo0, 32'd0);
    chk("rst_fd0", {31'd0, fd0}, 32'd0);
    chk("rst_sat0", {31'd0, sf0}, 32'd0);
    chk("rst_en2", {31'd0, eo2}, 32'd0);
    chk("rst_out2", oo2, 32'd0);
    chk("rst_sat2", {31'd0, sf2}, 32'd0);
    @(negedge clk);
    reset     = 1'b0;
    enable_in = 1'b0;
  endtask

  task automatic step(input logic en, input logic [31:0] d);
    int     n, pos, sh;
    longint s;
    logic   e_en, e_fd;
    logic [31:0] e_val;
    logic   o_en, o_fd, o_sf;
    logic [31:0] o_val;
    @(negedge clk);
    enable_in  = en;
    ifft_in_re = d;
    @(posedge clk);
    #1;
    n   = 0;
    pos = 0;
    if (en) begin
      raw.push_back(d);
      n   = raw.size() - 1;
      pos = n % 32;
    end
    for (int k = 0; k < 2; k++) begin
      sh    = (k == 0) ? 0 : 2;
      e_en  = en && (pos < 16);
      e_fd  = en && (pos == 31);
      e_val = '0;
      if (e_en) begin
        s = xs(raw[n], sh);
        if (n >= 32)
          s = s + xs(raw[n-16], sh);
        if (s > 64'sd2147483647) begin
          s = 64'sd2147483647;
          esat[k] = 1'b1;
        end else if (s < -64'sd2147483648) begin
          s = -64'sd2147483648;
          esat[k] = 1'b1;
        end
        e_val = s[31:0];
      end
      o_en  = (k == 0) ? eo0 : eo2;
      o_fd  = (k == 0) ? fd0 : fd2;
      o_sf  = (k == 0) ? sf0 : sf2;
      o_val = (k == 0) ? oo0 : oo2;
      chk($sformatf("en%0d", sh), {31'd0, o_en}, {31'd0, e_en});
      chk($sformatf("fdone%0d", sh), {31'd0, o_fd}, {31'd0, e_fd});
      chk($sformatf("sat%0d", sh), {31'd0, o_sf}, {31'd0, esat[k]});
      if (e_en)
        chk($sformatf("ola%0d_n%0d", sh, n), o_val, e_val);
    end
    if (eo0)
      pulses0++;
  endtask

  task automatic frame(input logic [31:0] v, input bit gap);
    for (int i = 0; i < 32; i++) begin
      step(1'b1, v);
      if (gap)
        step(1'b0, $urandom);
    end
  endtask

  initial begin
    reset      = 1'b1;
    enable_in  = 1'b0;
    ifft_in_re = '0;
    do_reset();

    for (int i = 0; i < 32; i++)
      step(1'b1, i);
    step(1'b0, 32'd0);

    do_reset();
    frame(32'd100, 1'b0);
    frame(32'd5, 1'b0);
    frame(32'd0, 1'b0);

    do_reset();
    for (int i = 0; i < 32; i++)
      step(1'b1, (i < 16) ? 32'd0 : 32'h7FFFFFF0);
    step(1'b1, 32'h00000100);
    chk("sat_pos_val", oo0, 32'h7FFFFFFF);
    for (int i = 1; i < 32; i++)
      step(1'b1, 32'd0);
    chk("sat_sticky", {31'd0, sf0}, 32'd1);

    do_reset();
    for (int i = 0; i < 32; i++)
      step(1'b1, (i < 16) ? 32'd0 : 32'h80000000);
    step(1'b1, 32'hFFFFFFFF);
    chk("sat_neg_val", oo0, 32'h80000000);

    do_reset();
    frame(32'd100, 1'b1);
    frame(32'd5, 1'b1);
    step(1'b0, 32'd0);

    do_reset();
    frame(32'd7, 1'b0);
    for (int i = 0; i < 21; i++)
      step(1'b1, 32'd7);
    do_reset();
    step(1'b1, 32'd3);
    chk("after_rst", oo0, 32'd3);
    for (int i = 1; i < 32; i++)
      step(1'b1, 32'd3);

    do_reset();
    pulses0 = 0;
    for (int i = 0; i < 128; i++)
      step(1'b1, $urandom);
    step(1'b0, 32'd0);
    chk("pulse_count", pulses0, 32'd64);

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule
